// File: rtl/seq_alu.sv
// seq_alu: multi-cycle signed ALU with valid/ready handshakes on input and output.
// MUL and DIV iterate one bit per cycle on operand magnitudes; all other ops finish in one cycle.
module seq_alu #(
  parameter int WIDTH         = 8,
  parameter int ALU_sel_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ALU_sel_WIDTH-1:0] alu_sel,
  input  logic [WIDTH-1:0]         bus_a,
  input  logic [WIDTH-1:0]         bus_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         alu_out,
  output logic                     zero,
  output logic                     negative,
  output logic                     overflow,
  output logic                     div_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [ALU_sel_WIDTH-1:0] OP_ADD = ALU_sel_WIDTH'(1);
  localparam logic [ALU_sel_WIDTH-1:0] OP_SUB = ALU_sel_WIDTH'(2);
  localparam logic [ALU_sel_WIDTH-1:0] OP_MUL = ALU_sel_WIDTH'(3);
  localparam logic [ALU_sel_WIDTH-1:0] OP_DIV = ALU_sel_WIDTH'(4);
  localparam logic [ALU_sel_WIDTH-1:0] OP_ASR = ALU_sel_WIDTH'(5);

  localparam logic [CW-1:0]    LAST_CNT  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_SHIFT = WIDTH'(WIDTH - 1);

  logic [1:0]               state_q, state_d;
  logic [ALU_sel_WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0]         a_q, a_d;
  logic [WIDTH-1:0]         b_q, b_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2*WIDTH-1:0]       prod_q, prod_d;
  logic [WIDTH-1:0]         rem_q, rem_d;
  logic [WIDTH-1:0]         quo_q, quo_d;
  logic [WIDTH-1:0]         alu_out_q, alu_out_d;
  logic                     zero_q, zero_d;
  logic                     negative_q, negative_d;
  logic                     overflow_q, overflow_d;
  logic                     div_zero_q, div_zero_d;

  // Single-cycle datapath works straight off the input bus during the accept cycle.
  logic [WIDTH-1:0] sum, diff, sh_amt, asr_res, mag_bus_a;
  logic             add_ov, sub_ov;

  assign sum       = bus_a + bus_b;
  assign diff      = bus_a - bus_b;
  assign add_ov    = (bus_a[WIDTH-1] == bus_b[WIDTH-1]) && (sum[WIDTH-1] != bus_a[WIDTH-1]);
  assign sub_ov    = (bus_a[WIDTH-1] != bus_b[WIDTH-1]) && (diff[WIDTH-1] != bus_a[WIDTH-1]);
  assign sh_amt    = (bus_b > MAX_SHIFT) ? MAX_SHIFT : bus_b;
  assign asr_res   = $signed(bus_a) >>> sh_amt;
  assign mag_bus_a = bus_a[WIDTH-1] ? -bus_a : bus_a;

  // Iterative datapath: magnitudes of the captured operands, sign fixed up at the end.
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               res_neg;
  logic [2*WIDTH-1:0] partial, prod_step, prod_fin;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [WIDTH-1:0]   rem_step, quo_step, div_res;
  logic               mul_ov, div_ov;

  assign mag_a     = a_q[WIDTH-1] ? -a_q : a_q;
  assign mag_b     = b_q[WIDTH-1] ? -b_q : b_q;
  assign res_neg   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign partial   = mag_b[cnt_q] ? ({{WIDTH{1'b0}}, mag_a} << cnt_q) : '0;
  assign prod_step = prod_q + partial;
  assign prod_fin  = res_neg ? -prod_step : prod_step;
  assign mul_ov    = !((&prod_fin[2*WIDTH-1:WIDTH-1]) || !(|prod_fin[2*WIDTH-1:WIDTH-1]));
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mag_b};
  assign rem_step  = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign quo_step  = {quo_q[WIDTH-2:0], ~div_trial[WIDTH]};
  assign div_res   = res_neg ? -quo_step : quo_step;
  // Only min_int / -1 yields a positive quotient with the MSB set.
  assign div_ov    = !res_neg && quo_step[WIDTH-1];

  logic             res_load;
  logic [WIDTH-1:0] res_val;
  logic             res_ov, res_dz;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    alu_out_d  = alu_out_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    overflow_d = overflow_q;
    div_zero_d = div_zero_q;
    res_load   = 1'b0;
    res_val    = '0;
    res_ov     = 1'b0;
    res_dz     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d     = alu_sel;
          a_d      = bus_a;
          b_d      = bus_b;
          cnt_d    = '0;
          prod_d   = '0;
          rem_d    = '0;
          quo_d    = mag_bus_a;
          res_load = 1'b1;
          case (alu_sel)
            OP_ADD: begin
              res_val = sum;
              res_ov  = add_ov;
            end
            OP_SUB: begin
              res_val = diff;
              res_ov  = sub_ov;
            end
            OP_MUL: res_load = 1'b0;
            OP_DIV: begin
              if (bus_b == '0) res_dz = 1'b1;
              else             res_load = 1'b0;
            end
            OP_ASR:  res_val = asr_res;
            default: res_val = bus_b;
          endcase
          state_d = res_load ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q == OP_MUL) begin
          prod_d = prod_step;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
        end
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          res_load = 1'b1;
          if (op_q == OP_MUL) begin
            res_val = prod_fin[WIDTH-1:0];
            res_ov  = mul_ov;
          end else begin
            res_val = div_res;
            res_ov  = div_ov;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (res_load) begin
      alu_out_d  = res_val;
      zero_d     = (res_val == '0);
      negative_d = res_val[WIDTH-1];
      overflow_d = res_ov;
      div_zero_d = res_dz;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      alu_out_q  <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      alu_out_q  <= alu_out_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign alu_out   = alu_out_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu; expected results are queued at issue and
// compared every cycle the DUT presents them, including latency and backpressure hold.
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   alu_sel = '0;
  logic [W-1:0] bus_a = '0;
  logic [W-1:0] bus_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] alu_out;
  logic         zero, negative, overflow, div_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit seen = 1'b0;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       ov;
    logic       dz;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb_q[$];

  seq_alu #(.WIDTH(W), .ALU_sel_WIDTH(3)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .bus_a(bus_a), .bus_b(bus_b),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .zero(zero), .negative(negative), .overflow(overflow), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model on plain integers: the true result, then range-checked into 8 bits.
  function automatic exp_t model(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sbv, full, amt;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    e.sel = sel; e.a = a; e.b = b;
    e.lat = 1; e.acc = 0; e.dz = 1'b0;
    case (sel)
      3'd1: full = sa + sbv;
      3'd2: full = sa - sbv;
      3'd3: begin full = sa * sbv; e.lat = W + 1; end
      3'd4: begin
        if (sbv == 0) begin full = 0; e.dz = 1'b1; end
        else begin full = sa / sbv; e.lat = W + 1; end
      end
      3'd5: begin
        amt = int'(b);
        if (amt > W - 1) amt = W - 1;
        full = sa >>> amt;
      end
      default: full = sbv;
    endcase
    e.ov  = (full > 127) || (full < -128);
    e.res = full[7:0];
    e.z   = (e.res == 8'd0);
    e.n   = e.res[7];
    return e;
  endfunction

  // Monitor: compares the head of the scoreboard on every valid cycle, pops on handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (rstn && out_valid) begin
      check_val("out_has_expect", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q[0];
        if (!seen) begin
          seen = 1'b1;
          check_val("latency", cyc - e.acc, e.lat);
        end
        check_val("alu_out", alu_out, e.res);
        check_val("zero", zero, e.z);
        check_val("negative", negative, e.n);
        check_val("overflow", overflow, e.ov);
        check_val("div_zero", div_zero, e.dz);
        check_val("in_ready_done", in_ready, 0);
        if (out_ready) begin
          $display("txn sel=%0d a=%0d b=%0d alu_out=%0d z=%0b n=%0b ov=%0b dz=%0b",
                   e.sel, $signed(e.a), $signed(e.b), $signed(alu_out),
                   zero, negative, overflow, div_zero);
          e = sb_q.pop_front();
          seen = 1'b0;
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b, input int stall);
    exp_t e;
    int t;
    int vcnt;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val("in_ready_idle", in_ready, 1);
    e = model(sel, a, b);
    e.acc = cyc;
    sb_q.push_back(e);
    alu_sel  = sel;
    bus_a    = a;
    bus_b    = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    alu_sel  = 3'($urandom);
    bus_a    = 8'($urandom);
    bus_b    = 8'($urandom);
    t = 0;
    vcnt = 0;
    while (sb_q.size() != 0 && t < 40) begin
      if (!out_valid) check_val("in_ready_busy", in_ready, 0);
      else begin
        vcnt++;
        if (vcnt > stall) out_ready = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    check_val("drained", sb_q.size(), 0);
    if (sb_q.size() != 0) begin
      sb_q.delete();
      seen = 1'b0;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_alu_out", alu_out, 0);
    check_val("rst_flags", {zero, negative, overflow, div_zero}, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_op(3'd1, 8'd100, 8'd50, 0);   // 150 wraps to -106, overflow
    run_op(3'd2, 8'd5,   8'd5,  0);
    run_op(3'd2, 8'h80,  8'd1,  0);   // -128 - 1
    run_op(3'd3, 8'hF9,  8'd6,  0);   // -7 * 6
    run_op(3'd3, 8'd20,  8'd20, 0);
    run_op(3'd4, 8'hF9,  8'd2,  0);   // -7 / 2
    run_op(3'd4, 8'd5,   8'd0,  0);
    run_op(3'd4, 8'h80,  8'hFF, 0);   // -128 / -1
    run_op(3'd5, 8'h80,  8'd3,  0);
    run_op(3'd5, 8'h80,  8'd9,  0);
    run_op(3'd5, 8'd64,  8'd200, 0);
    run_op(3'd7, 8'd0,   8'h5A, 0);
    run_op(3'd3, 8'hF9,  8'd6,  5);   // backpressure on an iterative op
    run_op(3'd1, 8'd100, 8'd50, 5);

    // Reset in the middle of a MUL: abandoned, no output.
    while (!in_ready) @(negedge clk);
    alu_sel = 3'd3; bus_a = 8'd20; bus_b = 8'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("busy_before_rst", {out_valid, in_ready}, 0);
    rstn = 1'b0;
    #1;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_in_ready", in_ready, 1);
    check_val("midrst_alu_out", alu_out, 0);
    check_val("midrst_flags", {zero, negative, overflow, div_zero}, 0);
    repeat (2) @(negedge clk);
    check_val("rst_hold_out_valid", out_valid, 0);
    rstn = 1'b1;
    @(negedge clk);
    run_op(3'd1, 8'd3, 8'd4, 0);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = (i % 6 == 0) ? 8'd0 : 8'($urandom);
      if (i % 8 == 1) ra = 8'h80;
      run_op(3'($urandom_range(0, 7)), ra, rb, int'($urandom_range(0, 2)));
    end
    run_op(3'd3, 8'h80, 8'h80, 1);    // -128 * -128
    run_op(3'd4, 8'h80, 8'd1, 0);     // -128 / 1, no overflow

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
